// File: rtl/tile_pkg.sv
// Shared definitions for the tile renderer: FSM encoding, colour defaults
// and the width helper for the map tile index.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic [15:0] DEF_KEY_COLOUR    = 16'h07E0;
  localparam logic [15:0] DEF_EXIT_COLOUR   = 16'h07E0;
  localparam logic [15:0] DEF_BLANK_COLOUR  = 16'h0000;
  localparam logic [15:0] DEF_BORDER_COLOUR = 16'h0000;
  localparam logic [15:0] DEF_REMAP_FROM    = 16'h0000;
  localparam logic [15:0] DEF_REMAP_TO      = 16'hFFE0;

  // Bits needed to address every tile of a map_w x map_h map (at least 1).
  function automatic int map_idx_w(input int map_w, input int map_h);
    int n;
    n = map_w * map_h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_colour_mux.sv
// Priority selection of the colour of one pixel from the sampled tile
// flags and the texels returned by the ROMs.
module tile_colour_mux
  import tile_pkg::*;
#(
  parameter logic [15:0] KEY_COLOUR    = DEF_KEY_COLOUR,
  parameter logic [15:0] EXIT_COLOUR   = DEF_EXIT_COLOUR,
  parameter logic [15:0] BLANK_COLOUR  = DEF_BLANK_COLOUR,
  parameter logic [15:0] BORDER_COLOUR = DEF_BORDER_COLOUR,
  parameter logic [15:0] REMAP_FROM    = DEF_REMAP_FROM,
  parameter logic [15:0] REMAP_TO      = DEF_REMAP_TO
) (
  input  logic        blank,
  input  logic        out_of_map,
  input  logic        player_tile,
  input  logic        exit_tile,
  input  logic        map_wall,
  input  logic [15:0] floor_texel,
  input  logic [15:0] wall_texel,
  input  logic [15:0] sprite_texel,
  output logic [15:0] colour
);

  // Highest-priority condition wins; a keyed sprite texel shows the floor.
  always_comb begin
    colour = floor_texel;
    if (blank) begin
      colour = BLANK_COLOUR;
    end else if (out_of_map) begin
      colour = BORDER_COLOUR;
    end else if (player_tile && (sprite_texel != KEY_COLOUR)) begin
      colour = (sprite_texel == REMAP_FROM) ? REMAP_TO : sprite_texel;
    end else if (player_tile) begin
      colour = floor_texel;
    end else if (exit_tile) begin
      colour = EXIT_COLOUR;
    end else if (map_wall) begin
      colour = wall_texel;
    end
  end

endmodule

// File: rtl/tile_renderer.sv
// Walks the screen in raster order, looks up each pixel's map tile and
// texel in external ROMs, and streams the chosen colour to the display
// with a write/ready handshake.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int          SCREEN_W      = 240,
  parameter int          SCREEN_H      = 320,
  parameter int          TILE_BITS     = 3,
  parameter int          MAP_W         = 30,
  parameter int          MAP_H         = 40,
  parameter int          ROM_LAT       = 2,
  parameter logic [15:0] KEY_COLOUR    = DEF_KEY_COLOUR,
  parameter logic [15:0] EXIT_COLOUR   = DEF_EXIT_COLOUR,
  parameter logic [15:0] BLANK_COLOUR  = DEF_BLANK_COLOUR,
  parameter logic [15:0] BORDER_COLOUR = DEF_BORDER_COLOUR,
  parameter logic [15:0] REMAP_FROM    = DEF_REMAP_FROM,
  parameter logic [15:0] REMAP_TO      = DEF_REMAP_TO,
  localparam int         MI_W          = map_idx_w(MAP_W, MAP_H),
  localparam int         X_W           = $clog2(SCREEN_W),
  localparam int         Y_W           = $clog2(SCREEN_H)
) (
  input  logic                   clock,
  input  logic                   resetApp,
  input  logic                   enable,
  input  logic                   blank,
  input  logic [7:0]             playerX,
  input  logic [7:0]             playerY,
  input  logic [MI_W-1:0]        exitIndex,
  output logic [MI_W-1:0]        mapAddr,
  input  logic                   mapWall,
  output logic [2*TILE_BITS-1:0] romAddr,
  input  logic [15:0]            floorTexel,
  input  logic [15:0]            wallTexel,
  input  logic [15:0]            spriteTexel,
  output logic [X_W-1:0]         xAddr,
  output logic [Y_W-1:0]         yAddr,
  output logic [15:0]            pixelData,
  output logic                   pixelWrite,
  input  logic                   pixelReady,
  output logic                   busy,
  output logic                   frameDone
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(SCREEN_H - 1);
  localparam logic [2:0]     LAT_LOAD = 3'(ROM_LAT);

  state_t         state;
  state_t         state_next;
  logic [2:0]     lat_cnt;
  logic [2:0]     lat_cnt_next;
  logic           accept;
  logic           last_pixel;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;
  logic [31:0]    col_next;
  logic [31:0]    row_next;
  logic [31:0]    idx_next;
  logic           oob_next;
  logic           oob_s;
  logic           blank_s;
  logic           player_s;
  logic           exit_s;
  logic           pixel_write_next;
  logic           busy_next;
  logic           frame_done_next;
  logic [15:0]    colour;

  assign accept     = pixelWrite & pixelReady;
  assign last_pixel = (xAddr == X_LAST) && (yAddr == Y_LAST);

  // State register and ROM latency counter.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
    end
  end

  // Next-state logic; the counter hits zero on the edge that enters PRESENT.
  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    case (state)
      IDLE: begin
        if (enable) state_next = FETCH;
      end
      FETCH: begin
        state_next   = WAIT;
        lat_cnt_next = LAT_LOAD;
      end
      WAIT: begin
        if (lat_cnt != 3'd0) lat_cnt_next = lat_cnt - 3'd1;
        if (lat_cnt <= 3'd1) state_next = PRESENT;
      end
      PRESENT: begin
        if (accept) state_next = (last_pixel && !enable) ? IDLE : FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered handshake and status outputs.
  always_comb begin
    pixel_write_next = (state_next == PRESENT);
    busy_next        = (state_next != IDLE);
    frame_done_next  = accept && last_pixel;
  end

  // Raster advance on accept, wrapping at the row and frame ends.
  always_comb begin
    x_next = xAddr;
    y_next = yAddr;
    if (accept) begin
      if (xAddr == X_LAST) begin
        x_next = '0;
        y_next = (yAddr == Y_LAST) ? '0 : yAddr + 1'b1;
      end else begin
        x_next = xAddr + 1'b1;
      end
    end
  end

  // Tile coordinates and map index of the pixel about to be fetched.
  always_comb begin
    col_next = 32'(x_next) >> TILE_BITS;
    row_next = 32'(y_next) >> TILE_BITS;
    oob_next = (col_next >= 32'(MAP_W)) || (row_next >= 32'(MAP_H));
    idx_next = row_next * 32'(MAP_W) + col_next;
  end

  // Datapath: addresses load on FETCH entry, per-pixel inputs are sampled
  // during FETCH, and the colour is captured on PRESENT entry.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      xAddr      <= '0;
      yAddr      <= '0;
      mapAddr    <= '0;
      romAddr    <= '0;
      oob_s      <= 1'b0;
      blank_s    <= 1'b0;
      player_s   <= 1'b0;
      exit_s     <= 1'b0;
      pixelData  <= '0;
      pixelWrite <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      xAddr <= x_next;
      yAddr <= y_next;
      if (state_next == FETCH) begin
        mapAddr <= oob_next ? '0 : MI_W'(idx_next);
        romAddr <= {y_next[TILE_BITS-1:0], x_next[TILE_BITS-1:0]};
        oob_s   <= oob_next;
      end
      if (state == FETCH) begin
        blank_s  <= blank;
        player_s <= (col_next == 32'(playerX)) && (row_next == 32'(playerY));
        exit_s   <= (mapAddr == exitIndex);
      end
      if ((state == WAIT) && (state_next == PRESENT)) pixelData <= colour;
      pixelWrite <= pixel_write_next;
      busy       <= busy_next;
      frameDone  <= frame_done_next;
    end
  end

  tile_colour_mux #(
    .KEY_COLOUR   (KEY_COLOUR),
    .EXIT_COLOUR  (EXIT_COLOUR),
    .BLANK_COLOUR (BLANK_COLOUR),
    .BORDER_COLOUR(BORDER_COLOUR),
    .REMAP_FROM   (REMAP_FROM),
    .REMAP_TO     (REMAP_TO)
  ) u_colour_mux (
    .blank       (blank_s),
    .out_of_map  (oob_s),
    .player_tile (player_s),
    .exit_tile   (exit_s),
    .map_wall    (mapWall),
    .floor_texel (floorTexel),
    .wall_texel  (wallTexel),
    .sprite_texel(spriteTexel),
    .colour      (colour)
  );

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 The module SHALL have parameter SCREEN_W, default 240, meaning display width in pixels.
REQ-002 The module SHALL have parameter SCREEN_H, default 320, meaning display height in pixels.
REQ-003 The module SHALL have parameter TILE_BITS, default 3, meaning log2 of the tile edge (8x8 tiles).
REQ-004 The module SHALL have parameters MAP_W and MAP_H, defaults 30 and 40, meaning map size in tiles.
REQ-005 The module SHALL have parameter ROM_LAT, default 2, meaning read latency in cycles of the map and tile ROMs (range 1..7).
REQ-006 The module SHALL have parameters KEY_COLOUR 16'h07E0, EXIT_COLOUR 16'h07E0, BLANK_COLOUR 16'h0000, BORDER_COLOUR 16'h0000, REMAP_FROM 16'h0000 and REMAP_TO 16'hFFE0.
REQ-007 The module SHALL have ports clock (in, 1, system clock) and resetApp (in, 1, reset); reset resetApp, asynchronous, active-high; clock clock.
REQ-008 The module SHALL have ports enable (in, 1, start or continue frames) and blank (in, 1, force BLANK_COLOUR).
REQ-009 The module SHALL have ports playerX (in, 8, player tile column), playerY (in, 8, player tile row) and exitIndex (in, clog2(MAP_W*MAP_H), exit tile index).
REQ-010 The module SHALL have ports mapAddr (out, clog2(MAP_W*MAP_H), tile index) and mapWall (in, 1, wall flag).
REQ-011 The module SHALL have ports romAddr (out, 2*TILE_BITS, texel address) and floorTexel, wallTexel, spriteTexel (in, 16 each).
REQ-012 The module SHALL have ports xAddr (out, clog2(SCREEN_W)), yAddr (out, clog2(SCREEN_H)), pixelData (out, 16), pixelWrite (out, 1) and pixelReady (in, 1).
REQ-013 The module SHALL have ports busy (out, 1, frame in progress) and frameDone (out, 1, one-cycle pulse).

Function
REQ-014 The module SHALL implement an FSM with states IDLE, FETCH, WAIT, PRESENT.
- IDLE->FETCH when enable=1.
- FETCH->WAIT always, loading the latency counter with ROM_LAT.
- WAIT->PRESENT when the counter reaches 0.
- PRESENT->FETCH on accept, or PRESENT->IDLE on accept of the last pixel.
REQ-015 In FETCH the module SHALL drive mapAddr=(y>>TILE_BITS)*MAP_W+(x>>TILE_BITS) and romAddr={y[TILE_BITS-1:0],x[TILE_BITS-1:0]}, and hold both constant until the pixel is accepted.
REQ-016 Tiles with column >= MAP_W or row >= MAP_H SHALL be out-of-map: mapAddr is driven to 0 and the pixel colour is BORDER_COLOUR.
REQ-017 Pixel colour SHALL be selected at PRESENT entry in this priority order:
- blank -> BLANK_COLOUR
- out-of-map -> BORDER_COLOUR
- player tile and spriteTexel!=KEY_COLOUR -> spriteTexel, with REMAP_FROM replaced by REMAP_TO
- player tile and keyed texel -> floorTexel
- mapAddr==exitIndex -> EXIT_COLOUR
- mapWall=1 -> wallTexel
- otherwise -> floorTexel
REQ-018 pixelWrite SHALL be 1 only in PRESENT; a pixel is accepted on the cycle with pixelWrite=1 and pixelReady=1.
REQ-019 xAddr, yAddr and pixelData SHALL remain stable while pixelWrite=1 and pixelReady=0.
REQ-020 On accept, xAddr SHALL increment; at SCREEN_W-1 it wraps to 0 and yAddr increments; at (SCREEN_W-1, SCREEN_H-1) both wrap to 0.
REQ-021 Accepting pixel (SCREEN_W-1, SCREEN_H-1) SHALL pulse frameDone for exactly one cycle; the FSM then returns to IDLE, or goes to FETCH if enable=1 in that cycle.
REQ-022 Deasserting enable mid-frame SHALL NOT stop the frame; enable is sampled only in IDLE and at frame end.
REQ-023 playerX, playerY, exitIndex and blank SHALL be sampled at FETCH, so a change takes effect from the next fetched pixel.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Steady-state throughput SHALL be one pixel per ROM_LAT+2 cycles when pixelReady is held at 1.

Reset
REQ-026 On resetApp, within the same cycle asynchronously:
- state <= IDLE
- xAddr, yAddr, mapAddr, romAddr <= 0
- pixelData <= 0; pixelWrite <= 0
- busy <= 0; frameDone <= 0
- latency counter <= 0
REQ-027 resetApp asserted mid-frame SHALL abandon the frame without a frameDone pulse; after release, the next frame starts at (0,0).

Structure
REQ-028 A shared package tile_pkg SHALL hold the FSM state encoding, the colour constants and a function for the clog2 width of the map index.
REQ-029 The pixel colour-selection priority logic SHALL be a sub-module tile_colour_mux.

Verification
REQ-030 The bench SHALL cover: reset release, enable=1, pixelReady=1, ROM_LAT=2 -> first accept at (0,0) on cycle 5 after enable, then one accept every 4 cycles.
REQ-031 The bench SHALL cover: pixelReady held 0 for 10 cycles in PRESENT -> pixelWrite=1 and xAddr, yAddr, pixelData unchanged throughout.
REQ-032 The bench SHALL cover: playerX=2, playerY=3, spriteTexel=16'h0000 at pixel (17,25) -> pixelData=16'hFFE0; with spriteTexel=16'h07E0 -> pixelData=floorTexel.
REQ-033 The bench SHALL cover: exitIndex=1198 with a full frame -> tile (28,39) pixels are 16'h07E0, and exactly one frameDone after 76800 accepts.
REQ-034 The bench SHALL cover: MAP_W=20 -> pixels with x>=160 are BORDER_COLOUR and mapAddr=0.
REQ-035 The bench SHALL cover: resetApp pulsed at pixel (100,50) -> outputs are at reset values within the same cycle, there is no frameDone, and after release the first accept is at (0,0).
